// File: rtl/rast_pixel_receiver_pkg.sv
// Shared constants and state encoding for the rasterizer pixel interface.
// Used by the receiver, the fake rasterizer and the scan-out reader.
package rast_pixel_receiver_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int COLOR_W_DEF = 3;
    localparam int ADDR_W_DEF  = 19;

    // Coordinate widths are fixed by the pixel interface, independent of resolution.
    localparam int X_W = 10;
    localparam int Y_W = 9;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        ACCEPT    = 2'd1,
        WAIT_SWAP = 2'd2
    } rx_state_t;

    function automatic int frame_pixels(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

endpackage

// File: rtl/rast_pixel_receiver_addr_calc.sv
// Purpose: (x, y) -> linear address y*H_RES + x by shift-add, plus range check.
// Latency: combinational; no backpressure (pure function of inputs).
module rast_addr_calc
    import rast_pixel_receiver_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    localparam logic [31:0] H_BITS = 32'(H_RES);

    // One shifted copy of y per set bit of the stride: 640 -> (y<<9)+(y<<7).
    always_comb begin
        addr = '0;
        for (int k = 0; k < ADDR_W; k++) begin
            if (H_BITS[k]) begin
                addr = addr + (ADDR_W'(y) << k);
            end
        end
        addr     = addr + ADDR_W'(x);
        in_range = (int'(x) < H_RES) && (int'(y) < V_RES);
    end

endmodule

// File: rtl/rast_pixel_receiver.sv
// Purpose: framebuffer-side pixel receiver: clear back bank, write pixels, swap on frame switch.
// Latency: ack/write 1 cycle after rdy; at most 1 pixel per 2 cycles, rdy held until ack.
module rast_pixel_receiver
    import rast_pixel_receiver_pkg::*;
#(
    parameter int                 H_RES       = H_RES_DEF,
    parameter int                 V_RES       = V_RES_DEF,
    parameter int                 COLOR_W     = COLOR_W_DEF,
    parameter int                 ADDR_W      = ADDR_W_DEF,
    parameter bit                 CLEAR_EN    = 1'b1,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rast_pixel_rdy,
    input  logic [COLOR_W-1:0] rast_color_input,
    input  logic [X_W-1:0]     rast_width,
    input  logic [Y_W-1:0]     rast_height,
    input  logic               rast_done,
    input  logic               next_frame_switch,
    output logic               read_rast_pixel_rdy,
    output logic               mem_we,
    output logic               mem_bank,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               display_bank,
    output logic               busy_clear,
    output logic               oob_flag
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(frame_pixels(H_RES, V_RES) - 1);

    rx_state_t         state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_in_range;

    rast_addr_calc #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .x        (rast_width),
        .y        (rast_height),
        .addr     (pix_addr),
        .in_range (pix_in_range)
    );

    // Writes always target the bank the display is not reading.
    assign mem_bank = ~display_bank;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= CLEAR_EN ? CLEAR : ACCEPT;
            clr_cnt             <= '0;
            read_rast_pixel_rdy <= 1'b0;
            mem_we              <= 1'b0;
            mem_addr            <= '0;
            mem_wdata           <= '0;
            display_bank        <= 1'b0;
            busy_clear          <= CLEAR_EN;
            oob_flag            <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    read_rast_pixel_rdy <= 1'b0;
                    busy_clear          <= 1'b1;
                    mem_we              <= 1'b1;
                    mem_addr            <= clr_cnt;
                    mem_wdata           <= CLEAR_COLOR;
                    if (clr_cnt == LAST_ADDR) begin
                        clr_cnt <= '0;
                        state   <= ACCEPT;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end

                ACCEPT: begin
                    busy_clear <= 1'b0;
                    // While the ack is showing, rdy still reflects the pixel just taken.
                    if (rast_pixel_rdy && !read_rast_pixel_rdy) begin
                        read_rast_pixel_rdy <= 1'b1;
                        if (pix_in_range) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= pix_addr;
                            mem_wdata <= rast_color_input;
                        end else begin
                            mem_we   <= 1'b0;
                            oob_flag <= 1'b1;
                        end
                    end else begin
                        read_rast_pixel_rdy <= 1'b0;
                        mem_we              <= 1'b0;
                    end
                    if (rast_done) begin
                        state <= WAIT_SWAP;
                    end
                end

                WAIT_SWAP: begin
                    read_rast_pixel_rdy <= 1'b0;
                    mem_we              <= 1'b0;
                    busy_clear          <= 1'b0;
                    if (next_frame_switch) begin
                        display_bank <= ~display_bank;
                        clr_cnt      <= '0;
                        state        <= CLEAR_EN ? CLEAR : ACCEPT;
                    end
                end

                default: begin
                    read_rast_pixel_rdy <= 1'b0;
                    mem_we              <= 1'b0;
                    state               <= ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rast_pixel_receiver.sv
// Directed bench for rast_pixel_receiver at 8x4 resolution with an expected-transaction model.
module tb_rast_pixel_receiver;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 3;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rast_pixel_rdy = 1'b0;
    logic [CW-1:0] rast_color_input = '0;
    logic [9:0]    rast_width = '0;
    logic [8:0]    rast_height = '0;
    logic          rast_done = 1'b0;
    logic          next_frame_switch = 1'b0;
    logic          read_rast_pixel_rdy;
    logic          mem_we;
    logic          mem_bank;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata;
    logic          display_bank;
    logic          busy_clear;
    logic          oob_flag;

    rast_pixel_receiver #(
        .H_RES       (H),
        .V_RES       (V),
        .COLOR_W     (CW),
        .ADDR_W      (AW),
        .CLEAR_EN    (1'b1),
        .CLEAR_COLOR (3'b000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rast_pixel_rdy      (rast_pixel_rdy),
        .rast_color_input    (rast_color_input),
        .rast_width          (rast_width),
        .rast_height         (rast_height),
        .rast_done           (rast_done),
        .next_frame_switch   (next_frame_switch),
        .read_rast_pixel_rdy (read_rast_pixel_rdy),
        .mem_we              (mem_we),
        .mem_bank            (mem_bank),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .display_bank        (display_bank),
        .busy_clear          (busy_clear),
        .oob_flag            (oob_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ack;
        bit we;
        int addr;
        int data;
        bit clr;
    } ev_t;

    ev_t q[$];
    bit  mdl_oob  = 1'b0;
    bit  mdl_disp = 1'b0;
    int  checks   = 0;
    int  errors   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endfunction

    function automatic void push_clear();
        for (int i = 0; i < H * V; i++) begin
            q.push_back('{ack: 1'b0, we: 1'b1, addr: i, data: 0, clr: 1'b1});
        end
    endfunction

    function automatic void push_pixel(input int x, input int y, input int c);
        bit inr;
        inr = (x < H) && (y < V);
        q.push_back('{ack: 1'b1, we: inr, addr: y * H + x, data: c, clr: 1'b0});
    endfunction

    // Expected-transaction scoreboard: every write or ack cycle consumes one entry.
    always @(negedge clk) begin
        if (rst) begin
            ev_t e;
            chk("display_bank", int'(display_bank), int'(mdl_disp));
            chk("mem_bank", int'(mem_bank), int'(!mdl_disp));
            if (mem_we || read_rast_pixel_rdy) begin
                if (q.size() == 0) begin
                    chk("unexpected_txn_we_ack", int'({mem_we, read_rast_pixel_rdy}), 0);
                end else begin
                    e = q.pop_front();
                    chk("txn_ack", int'(read_rast_pixel_rdy), int'(e.ack));
                    chk("txn_we", int'(mem_we), int'(e.we));
                    chk("txn_busy", int'(busy_clear), int'(e.clr));
                    if (e.we) begin
                        chk("txn_addr", int'(mem_addr), e.addr);
                        chk("txn_data", int'(mem_wdata), e.data);
                    end
                    if (e.ack && !e.we) mdl_oob = 1'b1;
                end
            end
            chk("oob_flag", int'(oob_flag), int'(mdl_oob));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain");
    endtask

    task automatic send_pixel(input int x, input int y, input int c, input bit done, output int lat);
        bit acked;
        push_pixel(x, y, c);
        rast_width       = 10'(x);
        rast_height      = 9'(y);
        rast_color_input = CW'(c);
        rast_done        = done;
        rast_pixel_rdy   = 1'b1;
        acked = 1'b0;
        lat   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (read_rast_pixel_rdy) begin
                acked = 1'b1;
                break;
            end
        end
        if (!acked) fail_now("pixel_ack");
        rast_pixel_rdy = 1'b0;
        rast_done      = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ack"}, int'(read_rast_pixel_rdy), 0);
        chk({tag, "_we"}, int'(mem_we), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_oob"}, int'(oob_flag), 0);
        chk({tag, "_disp"}, int'(display_bank), 0);
        chk({tag, "_bank"}, int'(mem_bank), 1);
        chk({tag, "_busy"}, int'(busy_clear), 1);
    endtask

    initial begin
        int  lat;
        bit  hit;

        repeat (2) step();
        check_reset_values("reset");

        push_clear();
        rst = 1'b1;
        drain(60);
        chk("busy_after_clear", int'(busy_clear), 0);
        chk("we_after_clear", int'(mem_we), 0);

        send_pixel(5, 2, 5, 1'b0, lat);
        chk("first_latency", lat, 1);
        chk("first_we", int'(mem_we), 1);
        chk("first_addr", int'(mem_addr), 21);
        chk("first_wdata", int'(mem_wdata), 5);
        step();
        chk("ack_single_cycle", int'(read_rast_pixel_rdy), 0);
        chk("we_single_cycle", int'(mem_we), 0);

        // Out-of-range pixel, then a new pixel presented during the ack cycle.
        send_pixel(9, 1, 2, 1'b0, lat);
        chk("oob_we", int'(mem_we), 0);
        chk("oob_set", int'(oob_flag), 1);
        send_pixel(7, 3, 6, 1'b0, lat);
        chk("back_to_back_latency", lat, 2);
        chk("corner_addr", int'(mem_addr), 31);
        chk("oob_sticky", int'(oob_flag), 1);
        send_pixel(2, 4, 1, 1'b0, lat);
        chk("oob_y_we", int'(mem_we), 0);
        step();

        // Frame switch while accepting: display must keep its bank.
        next_frame_switch = 1'b1;
        step();
        next_frame_switch = 1'b0;
        step();
        chk("switch_in_accept_disp", int'(display_bank), 0);
        send_pixel(1, 1, 2, 1'b0, lat);
        chk("post_switch_addr", int'(mem_addr), 9);
        chk("post_switch_bank", int'(mem_bank), 1);
        step();

        // Done together with a pixel: pixel lands first, then no more acks.
        send_pixel(0, 0, 7, 1'b1, lat);
        chk("done_pixel_addr", int'(mem_addr), 0);
        chk("done_pixel_wdata", int'(mem_wdata), 7);
        rast_width     = 10'd4;
        rast_height    = 9'd0;
        rast_pixel_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_swap_no_ack", int'(read_rast_pixel_rdy), 0);
        end
        rast_pixel_rdy = 1'b0;

        push_clear();
        next_frame_switch = 1'b1;
        step();
        next_frame_switch = 1'b0;
        mdl_disp = 1'b1;
        chk("swap_disp", int'(display_bank), 1);
        chk("swap_bank", int'(mem_bank), 0);

        // Reset in the middle of the clear of bank 0.
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (mem_we && int'(mem_addr) == 17) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("reach_clear_17");
        rst = 1'b0;
        #1;
        check_reset_values("midclear_reset");
        q.delete();
        mdl_oob  = 1'b0;
        mdl_disp = 1'b0;
        repeat (2) step();
        push_clear();
        rst = 1'b1;
        step();
        chk("restart_addr0_we", int'(mem_we), 1);
        chk("restart_addr0", int'(mem_addr), 0);
        drain(60);

        send_pixel(6, 1, 4, 1'b0, lat);
        chk("final_addr", int'(mem_addr), 14);
        chk("final_oob_cleared", int'(oob_flag), 0);
        step();
        drain(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rast_pixel_receiver.md
Name: rast_pixel_receiver

Overview:
Framebuffer-side receiver for the rasterizer pixel interface. It is the consumer that the rasterizer (and the fake rasterizer used for synthesis tests) drives.
- Accepts (x, y, colour) pixels with a ready/ack handshake.
- Converts each pixel to a linear address and writes it into the back bank of a double-buffered frame memory.
- Clears the back bank before each frame.
- Swaps banks on the display's frame-switch pulse once the rasterizer reports the frame done.

Parameters:
- H_RES, 640, pixels per line; also the address stride.
- V_RES, 480, lines per frame.
- COLOR_W, 3, colour bits per pixel.
- ADDR_W, 19, per-bank address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- CLEAR_EN, 1, 1 = clear the back bank before each frame; 0 = skip clearing (simulation speed-up).
- CLEAR_COLOR, 3'b000, value written during clear.

Ports:
- clk  input  1  system clock (100 MHz domain).
- rst  input  1  asynchronous, active-low reset.
- rast_pixel_rdy  input  1  rasterizer holds a valid pixel.
- rast_color_input  input  COLOR_W  pixel colour.
- rast_width  input  10  pixel x.
- rast_height  input  9  pixel y.
- rast_done  input  1  rasterizer finished the frame (level or pulse).
- next_frame_switch  input  1  one-cycle pulse from the display side at the frame boundary.
- read_rast_pixel_rdy  output  1  one-cycle pixel-accepted ack.
- mem_we  output  1  frame memory write enable.
- mem_bank  output  1  bank written (always the back bank).
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  COLOR_W  write data.
- display_bank  output  1  bank the scan-out side reads.
- busy_clear  output  1  high while the clear is in progress.
- oob_flag  output  1  sticky: an out-of-range pixel was dropped.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - read_rast_pixel_rdy=0, mem_we=0, mem_addr=0, mem_wdata=0, oob_flag=0.
  - display_bank=0, mem_bank=1.
  - State=CLEAR if CLEAR_EN, else ACCEPT.
  - busy_clear=CLEAR_EN.
- Reset mid-operation: any in-flight write is abandoned and the clear restarts from address 0 after release.
- Address rule: addr = y*H_RES + x. For H_RES=640 this is (y<<9)+(y<<7)+x; no multiplier is used.
- States:
  - CLEAR:
    - mem_we=1, mem_wdata=CLEAR_COLOR, mem_addr counts 0..H_RES*V_RES-1, one per cycle.
    - Ack is held low; rast_pixel_rdy is ignored.
    - After the last address: busy_clear=0, go to ACCEPT.
    - Lasts exactly H_RES*V_RES cycles.
  - ACCEPT:
    - Rasterizer drives rdy with x, y and colour, and holds them until it sees the ack.
    - rdy=1 sampled in cycle N → in cycle N+1 read_rast_pixel_rdy=1 and, if x<H_RES and y<V_RES, mem_we=1 with the captured addr and colour.
    - If out of range: mem_we=0, oob_flag set, pixel still acked.
    - rdy is ignored in the ack cycle, so max throughput is 1 pixel per 2 cycles and no pixel is double-captured.
    - rast_done with rdy=0 → WAIT_SWAP next cycle.
    - rast_done with rdy=1 in the same cycle → the pixel is written and acked first, then WAIT_SWAP.
    - next_frame_switch in ACCEPT is ignored: the display keeps the old bank, no tearing.
  - WAIT_SWAP:
    - No acks; rdy is ignored.
    - On the next_frame_switch pulse: toggle display_bank and mem_bank in the same cycle.
    - Then go to CLEAR (CLEAR_EN=1) or ACCEPT (CLEAR_EN=0).
    - A switch pulse arriving in the same cycle as entry into WAIT_SWAP counts.
- Invariants:
  - mem_bank == ~display_bank at all times.
  - mem_we is never high together with read_rast_pixel_rdy for an out-of-range pixel.
  - oob_flag is cleared only by reset.

Decomposition:
- Shared package/header: H_RES, V_RES, COLOR_W, ADDR_W, and the state encoding (CLEAR, ACCEPT, WAIT_SWAP). The fake rasterizer and the scan-out reader use the same constants.
- One natural sub-module, rast_addr_calc: combinational/registered x,y → linear address via the shift-add rule, reusable by the scan-out reader.

Test Plan:
- Reset release, CLEAR_EN=1, H_RES=8, V_RES=4 → 32 consecutive writes, addr 0..31, data 0, mem_bank=1; busy_clear falls after cycle 32; no ack during the clear.
- After clear, pixel x=5, y=2, colour=3'b101 held until ack → one cycle later ack=1, mem_we=1, addr=21, wdata=5; the ack is a single cycle.
- Pixel x=9, y=1 (out of range, H_RES=8) → ack=1, mem_we=0, oob_flag=1 and it stays 1 after later valid pixels.
- rast_done together with rdy for pixel (0,0) → write at addr 0, then WAIT_SWAP; next_frame_switch pulse → display_bank 0→1, mem_bank 1→0, then 32 clear writes to bank 0.
- next_frame_switch pulse while in ACCEPT (done not seen) → display_bank unchanged; following pixels still written to bank 1.
- rst asserted at clear address 17 → all outputs take reset values immediately; after release the clear restarts at addr 0.
